// File: rtl/wired_npc.sv
// ============================================================================
// wired_npc -- next-fetch-PC generator
//
// Produces one fetch-block request per two cycles toward the fetch target
// queue. After each accepted request it waits for the single-cycle fast
// predictor to decide where the next block starts. Backend and precise
// predictor redirects override the fast predictor. Each redirect advances a
// 2-bit epoch so that downstream logic can discard stale blocks.
//
// Parameters
//   PC_W        : PC width in bits
//   FETCH_BYTES : fetch block size in bytes (power of two, 4..64)
//   RESET_PC    : first fetch address after reset
//
// Ports
//   clk               : sole clock, rising edge
//   rst_n             : asynchronous reset, ACTIVE-HIGH despite the name
//   preq_valid_o      : prediction request valid (registered)
//   preq_ready_i      : request accepted by the FTQ
//   preq_pc_o         : fetch block start PC (registered)
//   preq_epoch_o      : redirect epoch of the request (registered)
//   pfast_valid_i     : fast predictor response valid
//   pfast_taken_i     : fast predictor says the block ends in a taken branch
//   pfast_target_i    : fast predicted target
//   pacc_valid_i      : precise predictor override valid
//   pacc_target_i     : precise override target
//   bk_redir_valid_i  : backend redirect (mispredict/exception)
//   bk_redir_pc_i     : backend redirect target
//
// Optional feature, macro WIRED_NPC_PERF_EN:
//   perf_bk_cnt_o     : number of backend redirects seen
//   perf_acc_cnt_o    : number of precise redirects that took effect
//   perf_req_cnt_o    : number of accepted requests
//   All three are 32-bit saturating counters cleared by reset.
// ============================================================================
module wired_npc #(
    parameter int              PC_W        = 32,
    parameter int              FETCH_BYTES = 16,
    parameter logic [PC_W-1:0] RESET_PC    = 32'h1C00_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            preq_valid_o,
    input  logic            preq_ready_i,
    output logic [PC_W-1:0] preq_pc_o,
    output logic [1:0]      preq_epoch_o,
    input  logic            pfast_valid_i,
    input  logic            pfast_taken_i,
    input  logic [PC_W-1:0] pfast_target_i,
    input  logic            pacc_valid_i,
    input  logic [PC_W-1:0] pacc_target_i,
    input  logic            bk_redir_valid_i,
    input  logic [PC_W-1:0] bk_redir_pc_i
`ifdef WIRED_NPC_PERF_EN
    ,
    output logic [31:0]     perf_bk_cnt_o,
    output logic [31:0]     perf_acc_cnt_o,
    output logic [31:0]     perf_req_cnt_o
`endif
);

    // Fetch block size and masks, all sized to the PC width.
    localparam logic [PC_W-1:0] BLK_SIZE   = PC_W'(FETCH_BYTES);
    localparam logic [PC_W-1:0] BLK_MASK   = ~(BLK_SIZE - {{(PC_W-1){1'b0}}, 1'b1});
    localparam logic [PC_W-1:0] WORD_MASK  = ~{{(PC_W-2){1'b0}}, 2'b11};

    typedef enum logic [1:0] {
        ST_HOLD      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_FAST = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [1:0]      epoch_q, epoch_d;
    logic            valid_q, valid_d;

    logic            redir_s;
    logic [PC_W-1:0] redir_tgt_s;
    logic            handshake_s;

    // Start of the next sequential fetch block; the add wraps naturally
    // at the top of the address space.
    function automatic logic [PC_W-1:0] seq_pc(input logic [PC_W-1:0] pc);
        return (pc & BLK_MASK) + BLK_SIZE;
    endfunction

    // Every target loaded into the PC is forced onto a 4-byte boundary.
    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return addr & WORD_MASK;
    endfunction

    // The request is accepted on the edge where the registered valid meets ready.
    assign handshake_s = valid_q & preq_ready_i;

    // Redirect selection: the backend always wins over the precise predictor.
    always_comb begin
        redir_s = bk_redir_valid_i | pacc_valid_i;
        if (bk_redir_valid_i) begin
            redir_tgt_s = word_align(bk_redir_pc_i);
        end else begin
            redir_tgt_s = word_align(pacc_target_i);
        end
    end

    // Next-state, next-PC and next-epoch logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;
        case (state_q)
            ST_HOLD: begin
                // Out of reset: always move on. A redirect here only steers
                // the first fetch; there is no older request to invalidate,
                // so the epoch is left alone.
                state_d = ST_ISSUE;
                if (redir_s) begin
                    pc_d = redir_tgt_s;
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_ISSUE: begin
                // A redirect wins even when the request is accepted on the
                // same edge: the accepted request carries the old epoch, and
                // the redirected block is presented next with the new one.
                if (redir_s) begin
                    pc_d    = redir_tgt_s;
                    epoch_d = epoch_q + 2'd1;
                    state_d = ST_ISSUE;
                end else if (handshake_s) begin
                    state_d = ST_WAIT_FAST;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_WAIT_FAST: begin
                if (redir_s) begin
                    // The fast response in this cycle (if any) is dropped.
                    pc_d    = redir_tgt_s;
                    epoch_d = epoch_q + 2'd1;
                    state_d = ST_ISSUE;
                end else if (pfast_valid_i) begin
                    if (pfast_taken_i) begin
                        pc_d = word_align(pfast_target_i);
                    end else begin
                        pc_d = seq_pc(pc_q);
                    end
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_WAIT_FAST;
                end
            end
            default: begin
                // Unreachable encoding: recover to a clean restart.
                state_d = ST_HOLD;
                pc_d    = RESET_PC;
                epoch_d = 2'd0;
            end
        endcase
        // Valid is registered: it is high exactly while the FSM sits in ISSUE.
        valid_d = (state_d == ST_ISSUE);
    end

    // FSM, PC, epoch and valid registers; note rst_n is active-high.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_HOLD;
            pc_q    <= RESET_PC;
            epoch_q <= 2'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
            valid_q <= valid_d;
        end
    end

    assign preq_valid_o = valid_q;
    assign preq_pc_o    = pc_q;
    assign preq_epoch_o = epoch_q;

`ifdef WIRED_NPC_PERF_EN
    logic [31:0] perf_bk_q;
    logic [31:0] perf_acc_q;
    logic [31:0] perf_req_q;

    // Saturating increment: sticks at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] cnt);
        if (cnt == 32'hFFFF_FFFF) begin
            return cnt;
        end else begin
            return cnt + 32'd1;
        end
    endfunction

    // Event counters; a precise redirect only counts when the backend
    // does not pre-empt it in the same cycle.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            perf_bk_q  <= 32'd0;
            perf_acc_q <= 32'd0;
            perf_req_q <= 32'd0;
        end else begin
            if (bk_redir_valid_i) begin
                perf_bk_q <= sat_inc(perf_bk_q);
            end else begin
                perf_bk_q <= perf_bk_q;
            end
            if (!bk_redir_valid_i && pacc_valid_i) begin
                perf_acc_q <= sat_inc(perf_acc_q);
            end else begin
                perf_acc_q <= perf_acc_q;
            end
            if (handshake_s) begin
                perf_req_q <= sat_inc(perf_req_q);
            end else begin
                perf_req_q <= perf_req_q;
            end
        end
    end

    assign perf_bk_cnt_o  = perf_bk_q;
    assign perf_acc_cnt_o = perf_acc_q;
    assign perf_req_cnt_o = perf_req_q;
`endif

endmodule

// File: tb/tb_wired_npc.sv
// Bench for wired_npc. The driver issues one cycle of stimulus at a time and
// advances a transaction-level reference model, which pushes the expected
// contents of each request into a scoreboard queue. A separate monitor on
// the falling edge pops and compares whenever a request is accepted.
module tb_wired_npc;

    localparam longint unsigned FB      = 64'd16;
    localparam longint unsigned SPAN    = 64'h1_0000_0000;
    localparam logic [31:0]     RST_PC  = 32'h1C00_0000;

    logic        clk;
    logic        rst_n;
    logic        preq_valid_o;
    logic        preq_ready_i;
    logic [31:0] preq_pc_o;
    logic [1:0]  preq_epoch_o;
    logic        pfast_valid_i;
    logic        pfast_taken_i;
    logic [31:0] pfast_target_i;
    logic        pacc_valid_i;
    logic [31:0] pacc_target_i;
    logic        bk_redir_valid_i;
    logic [31:0] bk_redir_pc_i;
`ifdef WIRED_NPC_PERF_EN
    logic [31:0] perf_bk_cnt_o;
    logic [31:0] perf_acc_cnt_o;
    logic [31:0] perf_req_cnt_o;
`endif

    wired_npc dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .preq_valid_o     (preq_valid_o),
        .preq_ready_i     (preq_ready_i),
        .preq_pc_o        (preq_pc_o),
        .preq_epoch_o     (preq_epoch_o),
        .pfast_valid_i    (pfast_valid_i),
        .pfast_taken_i    (pfast_taken_i),
        .pfast_target_i   (pfast_target_i),
        .pacc_valid_i     (pacc_valid_i),
        .pacc_target_i    (pacc_target_i),
        .bk_redir_valid_i (bk_redir_valid_i),
        .bk_redir_pc_i    (bk_redir_pc_i)
`ifdef WIRED_NPC_PERF_EN
        ,
        .perf_bk_cnt_o    (perf_bk_cnt_o),
        .perf_acc_cnt_o   (perf_acc_cnt_o),
        .perf_req_cnt_o   (perf_req_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [1:0]  ep;
    } req_t;

    req_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;

    // Reference model: "offering" = a request is being presented,
    // "awaiting" = a request was taken and the next block is not known yet,
    // neither = first cycle out of reset.
    bit              m_offer;
    bit              m_await;
    longint unsigned m_pc;
    int              m_ep;
    bit              m_valid_now;
    bit              m_redir_now;
    longint unsigned m_bk, m_acc, m_req;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_req();
        req_t r;
        r.pc = 32'(m_pc);
        r.ep = 2'(m_ep);
        exp_q.push_back(r);
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_offer = 1'b0;
        m_await = 1'b0;
        m_pc    = 64'(RST_PC);
        m_ep    = 0;
        m_valid_now = 1'b0;
        m_redir_now = 1'b0;
        m_bk = 0; m_acc = 0; m_req = 0;
    endtask

    // Effect of the coming rising edge, given this cycle's inputs.
    task automatic model_step(input bit bk, input logic [31:0] bkpc, input bit pacc,
                              input logic [31:0] paccpc, input bit pf, input bit pft,
                              input logic [31:0] pftg, input bit rdy);
        longint unsigned tgt;
        bit hs;
        bit redir;
        hs    = m_offer && rdy;
        redir = bk || pacc;
        m_valid_now = m_offer;
        m_redir_now = redir;
        tgt = bk ? 64'(bkpc) : 64'(paccpc);
        tgt = (tgt / 4) * 4;
        if (bk) m_bk++;
        else if (pacc) m_acc++;
        if (hs) m_req++;
        if (!m_offer && !m_await) begin
            if (redir) m_pc = tgt;
            m_offer = 1'b1;
            push_req();
        end else if (m_offer) begin
            if (redir) begin
                m_pc = tgt;
                m_ep = (m_ep + 1) % 4;
                // The unaccepted request is superseded; an accepted one stays.
                if (!hs) void'(exp_q.pop_back());
                push_req();
            end else if (hs) begin
                m_offer = 1'b0;
                m_await = 1'b1;
            end
        end else begin
            if (redir) begin
                m_pc = tgt;
                m_ep = (m_ep + 1) % 4;
                m_await = 1'b0; m_offer = 1'b1;
                push_req();
            end else if (pf) begin
                if (pft) m_pc = (64'(pftg) / 4) * 4;
                else     m_pc = ((m_pc / FB) * FB + FB) % SPAN;
                m_await = 1'b0; m_offer = 1'b1;
                push_req();
            end
        end
    endtask

    task automatic cyc(input bit bk, input logic [31:0] bkpc, input bit pacc,
                       input logic [31:0] paccpc, input bit pf, input bit pft,
                       input logic [31:0] pftg, input bit rdy);
        bk_redir_valid_i = bk;     bk_redir_pc_i  = bkpc;
        pacc_valid_i     = pacc;   pacc_target_i  = paccpc;
        pfast_valid_i    = pf;     pfast_taken_i  = pft;
        pfast_target_i   = pftg;   preq_ready_i   = rdy;
        model_step(bk, bkpc, pacc, paccpc, pf, pft, pftg, rdy);
        @(posedge clk);
        #1;
    endtask

    // Assert reset asynchronously, check it took effect at once, then release.
    task automatic do_reset();
        rst_n = 1'b1;
        mon_en = 1'b0;
        model_reset();
        #1;
        chk("rst_valid", 64'(preq_valid_o), 64'd0);
        chk("rst_pc",    64'(preq_pc_o),    64'(RST_PC));
        chk("rst_epoch", 64'(preq_epoch_o), 64'd0);
        pfast_valid_i = 1'b1; pfast_taken_i = 1'b1; pfast_target_i = 32'h0BAD_0000;
        preq_ready_i  = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n  = 1'b0;
        mon_en = 1'b1;
    endtask

    function automatic logic [31:0] pick_pc();
        case ($urandom_range(0, 3))
            0:       return 32'hFFFF_FF00 + 32'($urandom_range(0, 255));
            1:       return RST_PC + 32'($urandom_range(0, 511));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: checks valid every cycle, request contents on acceptance,
    // and that a stalled request holds its contents.
    req_t mon_r;
    always @(negedge clk) begin
        if (mon_en) begin
            chk("valid", 64'(preq_valid_o), 64'(m_valid_now));
            if (preq_valid_o && preq_ready_i) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_req actual=pc %0h required=no request", preq_pc_o);
                end else begin
                    mon_r = exp_q.pop_front();
                    chk("req_pc",    64'(preq_pc_o),    64'(mon_r.pc));
                    chk("req_epoch", 64'(preq_epoch_o), 64'(mon_r.ep));
                end
            end else if (preq_valid_o && !m_redir_now && exp_q.size() != 0) begin
                chk("stall_pc",    64'(preq_pc_o),    64'(exp_q[0].pc));
                chk("stall_epoch", 64'(preq_epoch_o), 64'(exp_q[0].ep));
            end
        end
    end

    initial begin
        rst_n = 1'b1;
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        do_reset();

        // Sequential fetch from the reset PC.
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("d_first_valid", 64'(preq_valid_o), 64'd1);
        chk("d_first_pc", 64'(preq_pc_o), 64'h1C00_0000);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("d_wait_valid", 64'(preq_valid_o), 64'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("d_seq1_pc", 64'(preq_pc_o), 64'h1C00_0010);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("d_seq2_pc", 64'(preq_pc_o), 64'h1C00_0020);
        chk("d_seq2_epoch", 64'(preq_epoch_o), 64'd0);

        // Taken prediction with a misaligned target.
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1C00_0103, 1'b1);
        chk("d_taken_pc", 64'(preq_pc_o), 64'h1C00_0100);

        // Backend beats precise beats fast, all in the same WAIT_FAST cycle.
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b1, 32'h0000_4000, 1'b1, 32'h0000_8000, 1'b1, 1'b1, 32'h00AB_CDE0, 1'b1);
        chk("d_prio_pc", 64'(preq_pc_o), 64'h0000_4000);
        chk("d_prio_epoch", 64'(preq_epoch_o), 64'd1);

        // Wrap at the top of the address space.
        cyc(1'b1, 32'hFFFF_FFF2, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("d_top_pc", 64'(preq_pc_o), 64'hFFFF_FFF0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b1);
        chk("d_wrap_pc", 64'(preq_pc_o), 64'h0000_0000);

        // Five stalled cycles with fast responses that must be ignored.
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h1234_5678, 1'b0);
            chk("d_stall_pc", 64'(preq_pc_o), 64'h0000_0000);
            chk("d_stall_valid", 64'(preq_valid_o), 64'd1);
        end

        // Redirect in HOLD keeps epoch 0, then back-to-back redirects.
        do_reset();
        cyc(1'b1, 32'h0000_1234, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("d_hold_pc", 64'(preq_pc_o), 64'h0000_1234);
        chk("d_hold_epoch", 64'(preq_epoch_o), 64'd0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1'b0, 32'd0, 1'b1, 32'(i * 256), 1'b0, 1'b0, 32'd0, 1'b0);
            chk("d_b2b_epoch", 64'(preq_epoch_o), 64'(i % 4));
            chk("d_b2b_pc", 64'(preq_pc_o), 64'(i * 256));
        end

        // Redirect on the same edge as an accepted request.
        cyc(1'b1, 32'h0000_5001, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        chk("d_hsredir_pc", 64'(preq_pc_o), 64'h0000_5000);
        chk("d_hsredir_epoch", 64'(preq_epoch_o), 64'd1);

        // Reset while waiting for the fast predictor discards the response.
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
        do_reset();
        chk("d_rstwait_valid", 64'(preq_valid_o), 64'd0);
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b1, 32'h0000_7770, 1'b0);
        chk("d_rstwait_pc", 64'(preq_pc_o), 64'(RST_PC));
        chk("d_rstwait_epoch", 64'(preq_epoch_o), 64'd0);

`ifdef WIRED_NPC_PERF_EN
        // Three accepted requests and one precise redirect.
        do_reset();
        cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 1'b1);
            cyc(1'b0, 32'd0, 1'b0, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0);
        end
        cyc(1'b0, 32'd0, 1'b1, 32'h0000_9000, 1'b0, 1'b0, 32'd0, 1'b0);
        chk("perf_req3", 64'(perf_req_cnt_o), 64'd3);
        chk("perf_acc1", 64'(perf_acc_cnt_o), 64'd1);
`endif

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cyc($urandom_range(0, 15) == 0, pick_pc(),
                    $urandom_range(0, 15) == 0, pick_pc(),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, pick_pc(),
                    $urandom_range(0, 3) != 0);
            end
        end

`ifdef WIRED_NPC_PERF_EN
        chk("perf_bk_end",  64'(perf_bk_cnt_o),  m_bk);
        chk("perf_acc_end", 64'(perf_acc_cnt_o), m_acc);
        chk("perf_req_end", 64'(perf_req_cnt_o), m_req);
`endif
        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
